// File: rtl/sprite_overlay_ctrl.sv
// rtl/sprite_overlay_ctrl.sv - sprite overlay with integer scaling, blink and wipe-reveal over a pipelined ROM
module sprite_overlay_ctrl #(
    parameter int          W            = 318,
    parameter int          H            = 11,
    parameter int          ROW_W        = 4,
    parameter int          COL_W        = 9,
    parameter int          SCALE_SH     = 0,
    parameter logic [11:0] TRANSPARENT  = 12'hFFF,
    parameter int          ROM_LAT      = 1,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bright,
    input  logic             en,
    input  logic [9:0]       hCount,
    input  logic [9:0]       vCount,
    input  logic [9:0]       x0,
    input  logic [9:0]       y0,
    input  logic [1:0]       mode,
    input  logic [11:0]      background,
    output logic [ROW_W-1:0] rom_row,
    output logic [COL_W-1:0] rom_col,
    input  logic [11:0]      rom_color,
    output logic [11:0]      rgb,
    output logic             frame_tick
);

    localparam int WS   = W << SCALE_SH;
    localparam int HS   = H << SCALE_SH;
    localparam int RC_W = COL_W + SCALE_SH + 1;
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [RC_W-1:0] STEP  = RC_W'(1 << SCALE_SH);
    localparam logic [RC_W-1:0] WS_RC = RC_W'(WS);

    typedef enum logic {SHOW, HIDE} blink_t;

    logic [9:0]      v_q;
    logic [9:0]      xl, yl;
    logic [1:0]      mode_prev;
    logic            en_prev;
    blink_t          state, state_nx;
    logic [BC_W-1:0] bcnt, bcnt_nx;
    logic [RC_W-1:0] rcnt;
    logic            mode_ok, reveal_ok, in_win, vis;
    logic [10:0]     h_end, v_end;
    logic [9:0]      dx, dy;
    logic            blink_entry, wipe_entry, en_rise;

    logic            vis_d    [ROM_LAT];
    logic            bright_d [ROM_LAT];
    logic [11:0]     bg_d     [ROM_LAT];

    // Position is only re-latched at frame start so mid-frame x0/y0 moves never tear the sprite.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q        <= '0;
            frame_tick <= 1'b0;
            xl         <= '0;
            yl         <= '0;
            mode_prev  <= 2'b00;
            en_prev    <= 1'b0;
        end else begin
            v_q        <= vCount;
            frame_tick <= (vCount == 10'd0) && (v_q != 10'd0);
            mode_prev  <= mode;
            en_prev    <= en;
            if (frame_tick) begin
                xl <= x0;
                yl <= y0;
            end
        end
    end

    assign h_end   = {1'b0, xl} + 11'(WS);
    assign v_end   = {1'b0, yl} + 11'(HS);
    assign in_win  = ({1'b0, hCount} >= {1'b0, xl}) && ({1'b0, hCount} < h_end) &&
                     ({1'b0, vCount} >= {1'b0, yl}) && ({1'b0, vCount} < v_end);
    assign dx      = hCount - xl;
    assign dy      = vCount - yl;
    assign rom_col = COL_W'(dx >> SCALE_SH);
    assign rom_row = ROW_W'(dy >> SCALE_SH);

    assign blink_entry = (mode == 2'b10) && (mode_prev != 2'b10);
    assign wipe_entry  = (mode == 2'b11) && (mode_prev != 2'b11);
    assign en_rise     = en && !en_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHOW;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            bcnt  <= bcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        if (blink_entry) begin
            state_nx = SHOW;
            bcnt_nx  = '0;
        end else if ((mode == 2'b10) && frame_tick) begin
            if (bcnt == BC_W'(BLINK_FRAMES - 1)) begin
                bcnt_nx  = '0;
                state_nx = (state == SHOW) ? HIDE : SHOW;
            end else begin
                bcnt_nx = bcnt + 1'b1;
            end
        end
    end

    always_comb begin
        mode_ok = (mode == 2'b01) || ((mode == 2'b10) && (state == SHOW)) || (mode == 2'b11);
    end

    // A clear on mode entry outranks a coincident frame_tick, so the first wipe frame is always empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
        end else if (wipe_entry || en_rise) begin
            rcnt <= '0;
        end else if (frame_tick && (mode == 2'b11)) begin
            rcnt <= (rcnt >= WS_RC - STEP) ? WS_RC : rcnt + STEP;
        end
    end

    assign reveal_ok = (mode != 2'b11) || (32'(dx) < 32'(rcnt));
    assign vis       = in_win && en && mode_ok && reveal_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                vis_d[i]    <= 1'b0;
                bright_d[i] <= 1'b0;
                bg_d[i]     <= '0;
            end
        end else begin
            vis_d[0]    <= vis;
            bright_d[0] <= bright;
            bg_d[0]     <= background;
            for (int i = 1; i < ROM_LAT; i++) begin
                vis_d[i]    <= vis_d[i-1];
                bright_d[i] <= bright_d[i-1];
                bg_d[i]     <= bg_d[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= '0;
        end else if (!bright_d[ROM_LAT-1]) begin
            rgb <= '0;
        end else if (vis_d[ROM_LAT-1] && (rom_color != TRANSPARENT)) begin
            rgb <= rom_color;
        end else begin
            rgb <= bg_d[ROM_LAT-1];
        end
    end

endmodule

// File: tb/tb_sprite_overlay_ctrl.sv
// tb/tb_sprite_overlay_ctrl.sv - scoreboard bench for sprite_overlay_ctrl (1x/ROM_LAT=1 and 2x/ROM_LAT=3 instances)
module tb_sprite_overlay_ctrl;

    logic        clk = 1'b0;
    logic        rst, bright, en;
    logic [9:0]  hCount, vCount, x0, y0;
    logic [1:0]  mode;
    logic [11:0] background;

    logic [3:0]  rom_row_a, rom_row_b;
    logic [8:0]  rom_col_a, rom_col_b;
    logic [11:0] rom_color_a, rom_color_b, rgb_a, rgb_b;
    logic        ft_a, ft_b;
    logic [11:0] rb1, rb2, rb3;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int ex_xl = 0;
    int ex_yl = 0;

    typedef struct {
        int          due;
        logic [11:0] exp;
        int          h;
        int          v;
    } sb_t;
    sb_t qa[$];
    sb_t qb[$];
    sb_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_overlay_ctrl #(
        .W(8), .H(4), .ROW_W(4), .COL_W(9), .SCALE_SH(0), .TRANSPARENT(12'hFFF),
        .ROM_LAT(1), .BLINK_FRAMES(2)
    ) dut_a (
        .clk(clk), .rst(rst), .bright(bright), .en(en), .hCount(hCount), .vCount(vCount),
        .x0(x0), .y0(y0), .mode(mode), .background(background), .rom_row(rom_row_a),
        .rom_col(rom_col_a), .rom_color(rom_color_a), .rgb(rgb_a), .frame_tick(ft_a)
    );

    sprite_overlay_ctrl #(
        .W(8), .H(4), .ROW_W(4), .COL_W(9), .SCALE_SH(1), .TRANSPARENT(12'hFFF),
        .ROM_LAT(3), .BLINK_FRAMES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .bright(bright), .en(en), .hCount(hCount), .vCount(vCount),
        .x0(x0), .y0(y0), .mode(mode), .background(background), .rom_row(rom_row_b),
        .rom_col(rom_col_b), .rom_color(rom_color_b), .rgb(rgb_b), .frame_tick(ft_b)
    );

    // External ROM models: 1-clock for dut_a, 3-clock for dut_b.
    always @(posedge clk) begin
        rom_color_a <= (rom_col_a == 9'd5) ? 12'hFFF : 12'h0F0;
        rb1 <= {4'hA, rom_row_b, rom_col_b[3:0]};
        rb2 <= rb1;
        rb3 <= rb2;
    end
    assign rom_color_b = rb3;

    function automatic logic [11:0] bgfn(int h, int v);
        return {1'b1, 11'(h * 3 + v)};
    endfunction

    function automatic logic [11:0] exp_a(int h, int v, logic g);
        logic        win;
        logic [11:0] c;
        win = (h >= ex_xl) && (h < ex_xl + 8) && (v >= ex_yl) && (v < ex_yl + 4);
        c   = (h - ex_xl == 5) ? 12'hFFF : 12'h0F0;
        if (!bright) return 12'h000;
        if (win && g && en && (c != 12'hFFF)) return c;
        return bgfn(h, v);
    endfunction

    function automatic logic [11:0] exp_b(int h, int v, logic g);
        logic win;
        win = (h >= ex_xl) && (h < ex_xl + 16) && (v >= ex_yl) && (v < ex_yl + 8);
        if (!bright) return 12'h000;
        if (win && g && en) return {4'hA, 4'((v - ex_yl) / 2), 4'((h - ex_xl) / 2)};
        return bgfn(h, v);
    endfunction

    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].due <= cyc) begin
            ea = qa.pop_front();
            n_checks++;
            if (ea.due != cyc || rgb_a !== ea.exp) begin
                n_fail++;
                $display("FAIL rgb_a pixel (%0d,%0d): got %h expected %h", ea.h, ea.v, rgb_a, ea.exp);
            end
        end
        while (qb.size() > 0 && qb[0].due <= cyc) begin
            eb = qb.pop_front();
            n_checks++;
            if (eb.due != cyc || rgb_b !== eb.exp) begin
                n_fail++;
                $display("FAIL rgb_b pixel (%0d,%0d): got %h expected %h", eb.h, eb.v, rgb_b, eb.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int h, input int v, input logic ga, input logic gb);
        hCount     = 10'(h);
        vCount     = 10'(v);
        background = bgfn(h, v);
        qa.push_back('{cyc + 2, exp_a(h, v, ga), h, v});
        qb.push_back('{cyc + 4, exp_b(h, v, gb), h, v});
        tick();
    endtask

    task automatic scan(input int v, input int h0, input int h1, input logic g, input int rn);
        for (int h = h0; h <= h1; h++)
            px(h, v, g && (rn < 0 || h - ex_xl < rn), g && (rn < 0 || (h - ex_xl) / 2 < rn));
    endtask

    // Frame boundary: vCount 1 -> 0; an optional mode change lands on the frame_tick cycle.
    task automatic new_frame(input logic chg, input logic [1:0] m);
        hCount = 10'd0;
        vCount = 10'd1;
        tick();
        vCount = 10'd0;
        tick();
        if (chg) mode = m;
        tick();
        tick();
        ex_xl = int'(x0);
        ex_yl = int'(y0);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++; if (rgb_a !== 12'h000) begin n_fail++; $display("FAIL reset_rgb_a got %h expected 000", rgb_a); end
        n_checks++; if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL reset_rgb_b got %h expected 000", rgb_b); end
        n_checks++; if (ft_a !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick got %b expected 0", ft_a); end
        n_checks++; if (rom_col_a !== 9'd10) begin n_fail++; $display("FAIL reset_xl rom_col got %0d expected 10", rom_col_a); end
        n_checks++; if (rom_row_a !== 4'd10) begin n_fail++; $display("FAIL reset_yl rom_row got %0d expected 10", rom_row_a); end
        rst   = 1'b0;
        ex_xl = 0;
        ex_yl = 0;
        px(10, 10, 1'b1, 1'b1);
        n_checks++; if (rgb_a !== 12'h000) begin n_fail++; $display("FAIL release_a_1 got %h expected 000", rgb_a); end
        n_checks++; if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL release_b_1 got %h expected 000", rgb_b); end
        px(3, 1, 1'b1, 1'b1);
        n_checks++; if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL release_b_2 got %h expected 000", rgb_b); end
        px(4, 1, 1'b1, 1'b1);
        n_checks++; if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL release_b_3 got %h expected 000", rgb_b); end
        scan(2, 0, 17, 1'b1, -1);
    endtask

    task automatic test_frame_tick();
        hCount = 10'd0;
        vCount = 10'd3;
        tick();
        vCount = 10'd0;
        tick();
        n_checks++; if (ft_a !== 1'b1) begin n_fail++; $display("FAIL frame_tick_a_pulse got %b expected 1", ft_a); end
        n_checks++; if (ft_b !== 1'b1) begin n_fail++; $display("FAIL frame_tick_b_pulse got %b expected 1", ft_b); end
        tick();
        n_checks++; if (ft_a !== 1'b0) begin n_fail++; $display("FAIL frame_tick_one_clock got %b expected 0", ft_a); end
        tick();
        n_checks++; if (ft_a !== 1'b0) begin n_fail++; $display("FAIL frame_tick_held_zero got %b expected 0", ft_a); end
        ex_xl  = 50;
        ex_yl  = 40;
        hCount = 10'd57;
        vCount = 10'd41;
        #1;
        n_checks++; if (rom_col_a !== 9'd7) begin n_fail++; $display("FAIL latch_col_a got %0d expected 7", rom_col_a); end
        n_checks++; if (rom_row_a !== 4'd1) begin n_fail++; $display("FAIL latch_row_a got %0d expected 1", rom_row_a); end
        n_checks++; if (rom_col_b !== 9'd3) begin n_fail++; $display("FAIL latch_col_b got %0d expected 3", rom_col_b); end
        scan(41, 48, 68, 1'b1, -1);
    endtask

    task automatic test_steady();
        x0 = 10'd260;
        y0 = 10'd287;
        new_frame(1'b0, 2'b00);
        hCount = 10'd265;
        vCount = 10'd287;
        #1;
        n_checks++; if (rom_col_a !== 9'd5) begin n_fail++; $display("FAIL steady_col_a got %0d expected 5", rom_col_a); end
        n_checks++; if (rom_col_b !== 9'd2) begin n_fail++; $display("FAIL steady_col_b got %0d expected 2", rom_col_b); end
        scan(287, 255, 280, 1'b1, -1);
        x0 = 10'd300;
        scan(288, 255, 305, 1'b1, -1);
        bright = 1'b0;
        scan(289, 258, 270, 1'b1, -1);
        bright = 1'b1;
        new_frame(1'b0, 2'b00);
        scan(287, 255, 320, 1'b1, -1);
    endtask

    task automatic test_scale();
        x0 = 10'd100;
        y0 = 10'd50;
        new_frame(1'b0, 2'b00);
        for (int h = 100; h <= 103; h++) begin
            hCount = 10'(h);
            vCount = 10'd51;
            #1;
            n_checks++;
            if (rom_col_b !== 9'((h - 100) / 2)) begin
                n_fail++;
                $display("FAIL scale_col_b h=%0d got %0d expected %0d", h, rom_col_b, (h - 100) / 2);
            end
        end
        n_checks++; if (rom_row_b !== 4'd0) begin n_fail++; $display("FAIL scale_row_b got %0d expected 0", rom_row_b); end
        scan(51, 98, 118, 1'b1, -1);
        scan(57, 98, 118, 1'b1, -1);
    endtask

    task automatic test_blink();
        x0 = 10'd20;
        y0 = 10'd5;
        new_frame(1'b0, 2'b00);
        mode = 2'b10;
        scan(5, 0, 0, 1'b1, -1);
        scan(5, 18, 37, 1'b1, -1);
        for (int f = 1; f <= 5; f++) begin
            new_frame(1'b0, 2'b00);
            scan(5, 18, 37, ((f / 2) % 2) == 0, -1);
        end
        new_frame(1'b0, 2'b00);
        scan(5, 18, 37, 1'b0, -1);
        mode = 2'b01;
        scan(5, 0, 0, 1'b1, -1);
        scan(5, 18, 37, 1'b1, -1);
        mode = 2'b10;
        scan(5, 0, 0, 1'b1, -1);
        scan(6, 18, 37, 1'b1, -1);
        new_frame(1'b0, 2'b00);
        scan(5, 18, 37, 1'b1, -1);
        new_frame(1'b0, 2'b00);
        scan(5, 18, 37, 1'b0, -1);
        mode = 2'b00;
        scan(5, 0, 0, 1'b0, -1);
        scan(6, 18, 37, 1'b0, -1);
    endtask

    task automatic test_wipe();
        new_frame(1'b1, 2'b11);
        scan(5, 18, 37, 1'b1, 0);
        for (int n = 1; n <= 9; n++) begin
            new_frame(1'b0, 2'b00);
            scan(5, 18, 37, 1'b1, n);
        end
        en = 1'b0;
        scan(5, 18, 37, 1'b1, 9);
        en = 1'b1;
        scan(5, 0, 0, 1'b1, -1);
        scan(6, 18, 37, 1'b1, 0);
        new_frame(1'b0, 2'b00);
        scan(5, 18, 37, 1'b1, 1);
    endtask

    task automatic test_midline_reset();
        mode = 2'b01;
        scan(5, 18, 24, 1'b1, -1);
        hCount = 10'd25;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        ex_xl = 0;
        ex_yl = 0;
        px(26, 5, 1'b1, 1'b1);
        n_checks++; if (rgb_a !== 12'h000) begin n_fail++; $display("FAIL midline_a_1 got %h expected 000", rgb_a); end
        n_checks++; if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL midline_b_1 got %h expected 000", rgb_b); end
        px(3, 5, 1'b1, 1'b1);
        n_checks++; if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL midline_b_2 got %h expected 000", rgb_b); end
        px(4, 5, 1'b1, 1'b1);
        n_checks++; if (rgb_b !== 12'h000) begin n_fail++; $display("FAIL midline_b_3 got %h expected 000", rgb_b); end
        scan(5, 0, 20, 1'b1, -1);
        scan(2, 0, 20, 1'b1, -1);
    endtask

    initial begin
        rst        = 1'b1;
        bright     = 1'b1;
        en         = 1'b1;
        mode       = 2'b01;
        x0         = 10'd50;
        y0         = 10'd40;
        hCount     = 10'd10;
        vCount     = 10'd10;
        background = bgfn(10, 10);
        test_reset();
        test_frame_tick();
        test_steady();
        test_scale();
        test_blink();
        test_wipe();
        test_midline_reset();
        repeat (6) tick();
        n_checks++;
        if (qa.size() + qb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", qa.size() + qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
